// File: rtl/lc3_control_pkg.sv
// Shared types for the LC-3 control sequencer: one-hot state encoding, opcodes,
// memory-state encodings and small decode helpers.
package lc3_control_pkg;

  typedef enum logic [7:0] {
    StFetch     = 8'b0000_0001,
    StDecode    = 8'b0000_0010,
    StExecute   = 8'b0000_0100,
    StWriteback = 8'b0000_1000,
    StMemInd    = 8'b0001_0000,
    StMemRd     = 8'b0010_0000,
    StMemWr     = 8'b0100_0000,
    StUpdatePc  = 8'b1000_0000
  } state_e;

  typedef enum logic [1:0] {
    MemRead     = 2'd0,
    MemIndirect = 2'd1,
    MemWrite    = 2'd2,
    MemIdle     = 2'd3
  } mem_state_e;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  // Unlisted opcodes retire through UPDATE_PC as a NOP.
  function automatic state_e exec_next_state(logic [3:0] op);
    state_e nxt;
    case (op)
      OpAdd, OpAnd, OpNot, OpLea: nxt = StWriteback;
      OpLd, OpLdr:                nxt = StMemRd;
      OpLdi, OpSti:               nxt = StMemInd;
      OpSt, OpStr:                nxt = StMemWr;
      default:                    nxt = StUpdatePc;
    endcase
    return nxt;
  endfunction

  function automatic mem_state_e mem_state_of(state_e s);
    mem_state_e ms;
    case (s)
      StMemRd:  ms = MemRead;
      StMemInd: ms = MemIndirect;
      StMemWr:  ms = MemWrite;
      default:  ms = MemIdle;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Handshake and control bundle between the LC-3 sequencer (master) and the
// pipeline/memory side (slave).
interface lc3_control_fsm_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic [1:0]  mem_state;
  logic        br_taken;
  logic        mem_timeout;
  logic [15:0] instr_count;

  modport master (
    input  complete_instr, complete_data, IR_Exec, psr,
    output enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
    output mem_state, br_taken, mem_timeout, instr_count
  );

  modport slave (
    output complete_instr, complete_data, IR_Exec, psr,
    input  enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
    input  mem_state, br_taken, mem_timeout, instr_count
  );
endinterface

// File: rtl/lc3_wait_timer.sv
// Wait-state counter: cleared on state entry, counts while enabled, flags the
// cycle on which the configured limit is reached.
module lc3_wait_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (count_en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  // Counter starts at 0 on the first waiting cycle, so limit-1 marks the last allowed cycle.
  assign expired_o = count_en_i && (count_q == limit_i - Width'(1));

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multicycle control sequencer: one-hot Moore FSM driving stage enables and
// memory handshakes, with wait-state abort and a retired-instruction counter.
module lc3_control_fsm
  import lc3_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX   = 15,
  parameter int unsigned INSTR_WAIT_MAX = 15
) (
  input logic               clock,
  input logic               reset,
  lc3_control_fsm_if.master bus
);

  localparam int unsigned WaitMax = (MEM_WAIT_MAX > INSTR_WAIT_MAX) ? MEM_WAIT_MAX
                                                                    : INSTR_WAIT_MAX;
  localparam int unsigned CntW = ($clog2(WaitMax + 1) > 4) ? $clog2(WaitMax + 1) : 4;
  localparam logic [CntW-1:0] MemLimit   = CntW'(MEM_WAIT_MAX);
  localparam logic [CntW-1:0] InstrLimit = CntW'(INSTR_WAIT_MAX);

  state_e          state_q, state_d;
  mem_state_e      mem_state_q;
  logic            br_q, br_d;
  logic            timeout_q;
  logic [15:0]     instr_count_q;
  logic [3:0]      op_q;
  logic            wait_active, handshake, expired, timeout, state_change;
  logic [CntW-1:0] limit;
  logic            unused_ir_bits;

  assign wait_active  = state_q inside {StFetch, StMemInd, StMemRd, StMemWr};
  assign limit        = (state_q == StFetch) ? InstrLimit : MemLimit;
  assign handshake    = (state_q == StFetch) ? bus.complete_instr : bus.complete_data;
  assign timeout      = wait_active & expired & ~handshake;
  assign state_change = (state_d != state_q);

  lc3_wait_timer #(
    .Width (CntW)
  ) u_wait_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .clear_i    (state_change),
    .count_en_i (wait_active),
    .limit_i    (limit),
    .expired_o  (expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (bus.complete_instr) state_d = StDecode;
        else if (timeout)       state_d = StUpdatePc;
      end
      StDecode:    state_d = StExecute;
      StExecute:   state_d = exec_next_state(bus.IR_Exec[15:12]);
      StWriteback: state_d = StUpdatePc;
      StMemInd: begin
        if (bus.complete_data) state_d = (op_q == OpSti) ? StMemWr : StMemRd;
        else if (timeout)      state_d = StUpdatePc;
      end
      StMemRd: begin
        if (bus.complete_data) state_d = StWriteback;
        else if (timeout)      state_d = StUpdatePc;
      end
      StMemWr: begin
        if (bus.complete_data || timeout) state_d = StUpdatePc;
      end
      StUpdatePc:  state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  always_comb begin
    br_d = br_q;
    if (state_q == StExecute) begin
      case (bus.IR_Exec[15:12])
        OpBr:    br_d = |(bus.IR_Exec[11:9] & bus.psr);
        OpJmp:   br_d = 1'b1;
        default: br_d = 1'b0;
      endcase
    end
    // An aborted instruction must never redirect the PC.
    if (timeout) br_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StFetch;
      mem_state_q   <= MemIdle;
      br_q          <= 1'b0;
      timeout_q     <= 1'b0;
      instr_count_q <= 16'h0000;
      op_q          <= 4'h0;
    end else begin
      state_q     <= state_d;
      mem_state_q <= mem_state_of(state_d);
      br_q        <= br_d;
      if (state_q == StExecute)  op_q <= bus.IR_Exec[15:12];
      if (timeout)               timeout_q <= 1'b1;
      if (state_q == StUpdatePc) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign bus.enable_fetch     = ~reset & (state_q == StFetch);
  assign bus.enable_decode    = ~reset & (state_q == StDecode);
  assign bus.enable_execute   = ~reset & (state_q == StExecute);
  assign bus.enable_writeback = ~reset & (state_q == StWriteback);
  assign bus.enable_updatePC  = ~reset & (state_q == StUpdatePc);
  assign bus.mem_state        = reset ? MemIdle : mem_state_q;
  assign bus.br_taken         = br_q;
  assign bus.mem_timeout      = timeout_q;
  assign bus.instr_count      = instr_count_q;

  assign unused_ir_bits = ^bus.IR_Exec[8:0];

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: a driver plans each instruction's stage
// trace from the opcode rules and wait counts; a monitor checks retirements.
module tb_lc3_control_fsm;

  localparam int MemMax   = 15;
  localparam int InstrMax = 15;

  typedef struct {
    string       path;
    bit          br;
    bit          to;
    logic [15:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lc3_control_fsm_if bus ();

  lc3_control_fsm #(
    .MEM_WAIT_MAX   (MemMax),
    .INSTR_WAIT_MAX (InstrMax)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt  = 16'h0000;
  bit          m_to   = 1'b0;
  string       tr;
  byte         tok_q[$];
  bit          hs_q[$];

  task automatic step(input bit ci, input bit cd);
    bus.complete_instr = ci;
    bus.complete_data  = cd;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input byte t, input bit h);
    tr = $sformatf("%s%c", tr, t);
    tok_q.push_back(t);
    hs_q.push_back(h);
  endtask

  // A waiting state lasts w cycles then handshakes, or aborts after lim silent cycles.
  task automatic phase(input byte t, input int w, input int lim, inout bit to);
    if (w >= lim) begin
      repeat (lim) add(t, 1'b0);
      to = 1'b1;
    end else begin
      repeat (w) add(t, 1'b0);
      add(t, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [2:0] p,
                           input int wf, input int w1, input int w2);
    bit       to = 1'b0;
    bit       br = 1'b0;
    int       op;
    op = int'(ir[15:12]);
    tr = "";
    tok_q.delete();
    hs_q.delete();
    phase("F", wf, InstrMax, to);
    if (!to) begin
      add("D", 1'b0);
      add("E", 1'b0);
      case (op)
        1, 5, 9, 14: add("W", 1'b0);
        2, 6: begin
          phase("R", w1, MemMax, to);
          if (!to) add("W", 1'b0);
        end
        10: begin
          phase("I", w1, MemMax, to);
          if (!to) phase("R", w2, MemMax, to);
          if (!to) add("W", 1'b0);
        end
        11: begin
          phase("I", w1, MemMax, to);
          if (!to) phase("S", w2, MemMax, to);
        end
        3, 7: phase("S", w1, MemMax, to);
        0:    br = |(ir[11:9] & p);
        12:   br = 1'b1;
        default: ;
      endcase
    end
    add("U", 1'b0);
    if (to) begin
      m_to = 1'b1;
      br   = 1'b0;
    end
    exp_q.push_back('{tr, br, m_to, m_cnt});
    m_cnt = m_cnt + 16'd1;
    bus.IR_Exec = ir;
    bus.psr     = p;
    foreach (tok_q[i]) begin
      if (tok_q[i] == "F")
        step(hs_q[i], 1'($urandom));
      else if (tok_q[i] == "I" || tok_q[i] == "R" || tok_q[i] == "S")
        step(1'($urandom), hs_q[i]);
      else
        step(1'($urandom), 1'($urandom));
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'($urandom), 1'($urandom));
    reset = 1'b0;
    exp_q.delete();
    m_cnt = 16'h0000;
    m_to  = 1'b0;
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 17))
                                       : int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor
  string obs = "";
  logic  prev_rst = 1'b0;
  byte   m_tok;
  int    m_ones;
  exp_t  m_e;

  always @(negedge clock) begin
    m_ones = int'(bus.enable_fetch) + int'(bus.enable_decode) + int'(bus.enable_execute)
           + int'(bus.enable_writeback) + int'(bus.enable_updatePC);
    if (reset) begin
      chk("reset_outputs", {m_ones, 2'b00} | 32'(bus.mem_state), 32'd3);
      if (prev_rst) begin
        chk("reset_count", 32'(bus.instr_count), 32'd0);
        chk("reset_flags", {30'd0, bus.mem_timeout, bus.br_taken}, 32'd0);
      end
      obs = "";
    end else begin
      if (bus.enable_fetch)          m_tok = "F";
      else if (bus.enable_decode)    m_tok = "D";
      else if (bus.enable_execute)   m_tok = "E";
      else if (bus.enable_writeback) m_tok = "W";
      else if (bus.enable_updatePC)  m_tok = "U";
      else if (bus.mem_state == 2'd1) m_tok = "I";
      else if (bus.mem_state == 2'd0) m_tok = "R";
      else if (bus.mem_state == 2'd2) m_tok = "S";
      else                            m_tok = "?";
      checks++;
      if (!((m_ones == 1 && bus.mem_state == 2'd3) || (m_ones == 0 && bus.mem_state != 2'd3)))
      begin
        errors++;
        $display("FAIL enable_onehot: got enables=%0d mem_state=%0d", m_ones, bus.mem_state);
      end
      obs = $sformatf("%s%c", obs, m_tok);
      if (bus.enable_updatePC) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got trace %s want none", obs);
        end else begin
          m_e = exp_q.pop_front();
          checks++;
          if (obs != m_e.path) begin
            errors++;
            $display("FAIL path: got %s want %s", obs, m_e.path);
          end
          chk("br_taken", 32'(bus.br_taken), 32'(m_e.br));
          chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_e.to));
          chk("instr_count", 32'(bus.instr_count), 32'(m_e.cnt));
        end
        obs = "";
      end
    end
    prev_rst = reset;
  end

  // Driver
  initial begin
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.IR_Exec        = 16'h0000;
    bus.psr            = 3'b000;
    do_reset(3);

    run_instr(16'h1042, 3'b001, 2, 0, 0);   // ADD, fetch waits two cycles
    run_instr(16'hA5FF, 3'b001, 0, 0, 0);   // LDI
    run_instr(16'h0402, 3'b010, 0, 0, 0);   // BRz taken
    run_instr(16'h0402, 3'b100, 0, 0, 0);   // BRz not taken
    run_instr(16'h3001, 3'b001, 0, 14, 0);  // handshake on the last allowed cycle
    run_instr(16'h6ABC, 3'b010, 1, 3, 0);   // LDR
    run_instr(16'hB123, 3'b100, 1, 2, 1);   // STI
    run_instr(16'hC1C0, 3'b000, 0, 0, 0);   // JMP
    run_instr(16'hD000, 3'b111, 0, 0, 0);   // reserved -> NOP
    run_instr(16'h3001, 3'b001, 0, 40, 0);  // ST never completes
    run_instr(16'h5000, 3'b001, 0, 0, 0);   // flag stays set
    run_instr(16'h1000, 3'b001, InstrMax, 0, 0); // fetch abort

    do_reset(2);
    for (int i = 0; i < 80; i++) begin
      run_instr(16'($urandom), 3'($urandom), pick_wait(), pick_wait(), pick_wait());
    end

    do_reset(2);
    dut.instr_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    run_instr(16'h1042, 3'b001, 0, 0, 0);
    run_instr(16'hE000, 3'b001, 0, 0, 0);   // retires with count wrapped to 0

    // Abandon an LD while MEM_RD waits for data.
    bus.IR_Exec = 16'h2000;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    do_reset(2);
    run_instr(16'h1042, 3'b001, 0, 0, 0);
    run_instr(16'h0E00, 3'b001, 1, 0, 0);

    repeat (3) step(1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
